// File: rtl/ps2_key_event.sv
// PS2 gamepad button debouncer + press/release event FIFO with valid/ready head.
// Optional `AUTOREPEAT_EN adds held-button repeat press events (REP_DELAY/REP_RATE frames).
module ps2_key_event #(
  parameter int DEB_FRAMES     = 3,
  parameter int DEPTH          = 8,
  parameter bit KEY_ACTIVE_LOW = 1'b0
`ifdef AUTOREPEAT_EN
  , parameter int REP_DELAY    = 30,
  parameter int REP_RATE       = 6
`endif
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  input  logic       key_upd,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic [9:0] key_state,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int NK = 10;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CMAX = 4'(DEB_FRAMES - 1);

  logic [NK-1:0]       k;
  logic [NK-1:0]       ks_q, ks_d, pend_q, pend_d;
  logic [NK-1:0]       flip, rep_set, scan_clr;
  logic [NK-1:0][3:0]  cnt_q, cnt_d;
  logic                ovf_q, ovf_d, loss;

  logic [3:0]          sel;
  logic                any_pend, full, pop, push;
  logic [4:0]          push_data;

  logic [DEPTH-1:0][4:0] mem_q;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         fcnt_q, fcnt_d, rem;
  logic                vld_q, vld_d;
  logic [4:0]          dat_q, dat_d;

  assign k = KEY_ACTIVE_LOW ? ~key_in : key_in;

  // Per-button debounce: a frame agreeing with the stable level restarts the count.
  always_comb begin
    ks_d  = ks_q;
    cnt_d = cnt_q;
    flip  = '0;
    for (int i = 0; i < NK; i++) begin
      if (key_upd) begin
        if (k[i] == ks_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          ks_d[i]  = k[i];
          cnt_d[i] = '0;
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REP_DELAY + 1);
  logic [NK-1:0][RW-1:0] rep_q, rep_d;

  // After the first hit the counter rewinds by REP_RATE so later hits land every REP_RATE frames.
  always_comb begin
    rep_d   = rep_q;
    rep_set = '0;
    for (int i = 0; i < NK; i++) begin
      if (!ks_q[i] || flip[i]) begin
        rep_d[i] = '0;
      end else if (key_upd) begin
        if (rep_q[i] + RW'(1) == RW'(REP_DELAY)) begin
          rep_set[i] = 1'b1;
          rep_d[i]   = RW'(REP_DELAY - REP_RATE);
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign rep_set = '0;
`endif

  // Lowest pending index wins the single push slot each cycle.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel      = 4'(i);
        any_pend = 1'b1;
      end
    end
  end

  assign full      = (fcnt_q == (AW+1)'(DEPTH));
  assign pop       = vld_q & evt_ready;
  assign push      = any_pend & (~full | pop);
  assign push_data = {ks_q[sel], sel};
  assign scan_clr  = push ? (NK'(1) << sel) : '0;

  // An edge being pushed this cycle is not lost even if the same bit flips again.
  assign loss   = |(flip & pend_q & ~scan_clr);
  assign pend_d = (pend_q & ~scan_clr) | flip | rep_set;
  assign ovf_d  = loss | (ovf_q & ~ovf_clr);

  assign wr_d   = wr_q + AW'(push);
  assign rd_d   = rd_q + AW'(pop);
  assign rem    = fcnt_q - (AW+1)'(pop);
  assign fcnt_d = rem + (AW+1)'(push);

  // Registered head: bypass the pushed word when it lands in an otherwise empty queue.
  always_comb begin
    vld_d = (fcnt_d != '0);
    dat_d = '0;
    if (fcnt_d != '0) dat_d = (rem == '0) ? push_data : mem_q[rd_d];
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ks_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      ks_q   <= ks_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (push) mem_q[wr_q] <= push_data;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

  assign evt_valid = vld_q;
  assign evt_data  = dat_q;
  assign key_state = ks_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event (DEB_FRAMES=3, DEPTH=8, active-high keys).
// With AUTOREPEAT_EN defined it also runs a REP_DELAY=4 / REP_RATE=2 repeat sequence.
module tb_ps2_key_event;
  logic       sys_clk = 1'b0;
  logic       rst;
  logic [9:0] key_in;
  logic       key_upd;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_data;
  logic [9:0] key_state;
  logic       ovf;
  logic       ovf_clr;

  int pass_cnt = 0;
  int total    = 0;

  always #5 sys_clk = ~sys_clk;

  ps2_key_event #(
    .DEB_FRAMES(3), .DEPTH(8), .KEY_ACTIVE_LOW(1'b0)
`ifdef AUTOREPEAT_EN
    , .REP_DELAY(4), .REP_RATE(2)
`endif
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .key_in(key_in), .key_upd(key_upd),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .key_state(key_state), .ovf(ovf), .ovf_clr(ovf_clr)
  );

`ifdef AUTOREPEAT_EN
  logic [4:0] log_q[$];
  always @(posedge sys_clk)
    if (!rst && evt_valid && evt_ready) log_q.push_back(evt_data);
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic frame(input logic [9:0] v);
    key_in  = v;
    key_upd = 1'b1;
    @(posedge sys_clk);
    #1;
    key_upd = 1'b0;
  endtask

  task automatic frames3(input logic [9:0] v);
    repeat (3) frame(v);
  endtask

  initial begin
    rst = 1'b1; key_in = '0; key_upd = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    chk("rst_valid", 16'(evt_valid), 16'h0);
    chk("rst_data",  16'(evt_data),  16'h00);
    chk("rst_state", 16'(key_state), 16'h000);
    chk("rst_ovf",   16'(ovf),       16'h0);
    rst = 1'b0;
    tick(1);

    // single press, debounced over 3 frames, held at head by evt_ready=0
    frame(10'h001); frame(10'h001);
    chk("deb_2frames", 16'(key_state), 16'h000);
    frame(10'h001);
    chk("deb_accept", 16'(key_state), 16'h001);
    chk("lat_e0", 16'(evt_valid), 16'h0);
    tick(1);
    chk("press0", 16'({evt_valid, evt_data}), 16'h30);
    tick(2);
    chk("press0_held", 16'({evt_valid, evt_data}), 16'h30);
    evt_ready = 1'b1;
    tick(1);
    chk("press0_popped", 16'(evt_valid), 16'h0);
    tick(3);
    chk("one_event", 16'(evt_valid), 16'h0);
    frames3(10'h000);
    tick(1);
    chk("release0", 16'({evt_valid, evt_data}), 16'h20);
    tick(1);

    // glitch on button 2 never reaches 3 frames
    frame(10'h004); frame(10'h004); frame(10'h000);
    tick(3);
    chk("glitch_state", 16'(key_state), 16'h000);
    chk("glitch_noevt", 16'(evt_valid), 16'h0);

    // buttons 3 and 7 in the same frame: two events on consecutive cycles
    frames3(10'h088);
    tick(1);
    chk("dual_first",  16'({evt_valid, evt_data}), 16'h33);
    tick(1);
    chk("dual_second", 16'({evt_valid, evt_data}), 16'h37);
    tick(1);
    chk("dual_empty",  16'(evt_valid), 16'h0);
    frames3(10'h000);
    tick(4);
    chk("dual_released", 16'({6'(evt_valid), key_state}), 16'h000);

    // backpressure: 10 presses into an 8-deep FIFO, then lose button 9's release edge
    evt_ready = 1'b0;
    frames3(10'h3FF);
    tick(10);
    chk("bp_head", 16'({evt_valid, evt_data}), 16'h30);
    chk("bp_no_ovf", 16'(ovf), 16'h0);
    frames3(10'h1FF);
    chk("bp_ovf", 16'(ovf), 16'h1);
    chk("bp_state", 16'(key_state), 16'h1FF);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      // presses 0..8 (5'h10..5'h18), then button 9 carrying its current released level
      logic [4:0] e;
      e = (i < 9) ? 5'(16 + i) : 5'h09;
      chk($sformatf("bp_drain%0d", i), 16'({evt_valid, evt_data}), 16'({1'b1, e}));
      tick(1);
    end
    chk("bp_empty", 16'(evt_valid), 16'h0);
    chk("ovf_sticky", 16'(ovf), 16'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 16'(ovf), 16'h0);

    // fill with releases, re-press button 8 while its release is still pending, then reset
    evt_ready = 1'b0;
    frames3(10'h000);
    tick(9);
    frames3(10'h100);
    chk("pre_rst_ovf", 16'(ovf), 16'h1);
    chk("pre_rst_valid", 16'(evt_valid), 16'h1);
    key_in = 10'h000;
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 16'(evt_valid), 16'h0);
    chk("async_state", 16'(key_state), 16'h000);
    chk("async_ovf",   16'(ovf),       16'h0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(5);
    chk("post_rst_quiet", 16'(evt_valid), 16'h0);

`ifdef AUTOREPEAT_EN
    // accept press, 10 held frames (repeats at 4,6,8,10), 3 release frames; the second
    // release frame is held frame 12 so it repeats once more before the release event
    log_q.delete();
    frames3(10'h020);
    repeat (10) frame(10'h020);
    frames3(10'h000);
    tick(5);
    chk("rep_count", 16'(log_q.size()), 16'd7);
    for (int i = 0; i < 7; i++) begin
      logic [4:0] e;
      e = (i < 6) ? 5'h15 : 5'h05;
      chk($sformatf("rep_evt%0d", i), (i < log_q.size()) ? 16'(log_q[i]) : 16'hFFFF, 16'(e));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
